// File: rtl/spmv_row_scheduler.sv
// Row sequencer for the SpMV accelerator: walks the CSR row-pointer array, launches the
// inner-product kernel once per non-empty row and writes each row result to y memory.
module spmv_row_scheduler #(
  parameter int ROW_W  = 16,
  parameter int IDX_W  = 32,
  parameter int DATA_W = 32
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              ap_start,
  output logic              ap_done,
  output logic              ap_idle,
  output logic              ap_ready,
  input  logic [ROW_W-1:0]  num_rows,
  output logic [ROW_W:0]    rp_addr,
  output logic              rp_ce,
  input  logic [IDX_W-1:0]  rp_q,
  output logic              k_start,
  input  logic              k_ready,
  input  logic              k_done,
  output logic [IDX_W-1:0]  k_begin,
  output logic [IDX_W-1:0]  k_end,
  input  logic [DATA_W-1:0] k_sum,
  output logic [ROW_W-1:0]  y_addr,
  output logic              y_ce,
  output logic              y_we,
  output logic [DATA_W-1:0] y_d,
  output logic              err_order
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD0,
    S_W0,
    S_RDN,
    S_WN,
    S_LAUNCH,
    S_RUN,
    S_WRITE,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [ROW_W-1:0]    nrows_q, nrows_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [IDX_W-1:0]    begin_q, begin_d;
  logic [IDX_W-1:0]    end_q, end_d;
  logic [DATA_W-1:0]   ydata_q, ydata_d;
  logic                err_q, err_d;
  logic [ROW_W-1:0]    row_inc;

  assign row_inc = row_q + ROW_W'(1);

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // the pre-edge values of its neighbours regardless of process ordering.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= S_IDLE;
      nrows_q <= '0;
      row_q   <= '0;
      begin_q <= '0;
      end_q   <= '0;
      ydata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      nrows_q <= nrows_d;
      row_q   <= row_d;
      begin_q <= begin_d;
      end_q   <= end_d;
      ydata_q <= ydata_d;
      err_q   <= err_d;
    end
  end

  // NOTE: every signal written here gets a default first; a path that skips an
  // assignment would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    nrows_d  = nrows_q;
    row_d    = row_q;
    begin_d  = begin_q;
    end_d    = end_q;
    ydata_d  = ydata_q;
    err_d    = err_q;
    ap_done  = 1'b0;
    ap_ready = 1'b0;
    ap_idle  = 1'b0;
    rp_ce    = 1'b0;
    rp_addr  = '0;
    k_start  = 1'b0;
    y_ce     = 1'b0;
    y_we     = 1'b0;
    y_addr   = '0;
    y_d      = '0;

    unique case (state_q)
      S_IDLE: begin
        ap_idle = 1'b1;
        if (ap_start) begin
          nrows_d = num_rows;
          row_d   = '0;
          err_d   = 1'b0;
          state_d = (num_rows == '0) ? S_DONE : S_RD0;
        end
      end
      S_RD0: begin
        rp_ce   = 1'b1;
        state_d = S_W0;
      end
      S_W0: begin
        begin_d = rp_q;
        state_d = S_RDN;
      end
      S_RDN: begin
        rp_ce   = 1'b1;
        rp_addr = {1'b0, row_q} + (ROW_W + 1)'(1);
        state_d = S_WN;
      end
      S_WN: begin
        end_d = rp_q;
        if (rp_q > begin_q) begin
          state_d = S_LAUNCH;
        end else begin
          // Empty row, or a decreasing pointer that is flagged and treated as empty.
          ydata_d = '0;
          state_d = S_WRITE;
          if (rp_q < begin_q) err_d = 1'b1;
        end
      end
      S_LAUNCH: begin
        k_start = 1'b1;
        if (k_ready) begin
          if (k_done) begin
            ydata_d = k_sum;
            state_d = S_WRITE;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (k_done) begin
          ydata_d = k_sum;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        y_ce    = 1'b1;
        y_we    = 1'b1;
        y_addr  = row_q;
        y_d     = ydata_q;
        // rowptr[row+1] becomes the next row's begin without a second read.
        begin_d = end_q;
        row_d   = row_inc;
        state_d = (row_inc == nrows_q) ? S_DONE : S_RDN;
      end
      S_DONE: begin
        ap_done  = 1'b1;
        ap_ready = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign k_begin   = begin_q;
  assign k_end     = end_q;
  assign err_order = err_q;

endmodule

// File: tb/tb_spmv_row_scheduler.sv
// Self-checking bench for spmv_row_scheduler: row-pointer RAM and kernel responders, a
// CSR-level model producing expected launches and y writes, and a per-cycle compare process.
module tb_spmv_row_scheduler;

  logic        ap_clk;
  logic        ap_rst_n;
  logic        ap_start;
  logic        ap_done, ap_idle, ap_ready;
  logic [15:0] num_rows;
  logic [16:0] rp_addr;
  logic        rp_ce;
  logic [31:0] rp_q;
  logic        k_start, k_ready, k_done;
  logic [31:0] k_begin, k_end, k_sum;
  logic [15:0] y_addr;
  logic        y_ce, y_we;
  logic [31:0] y_d;
  logic        err_order;

  spmv_row_scheduler dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start),
    .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
    .num_rows(num_rows), .rp_addr(rp_addr), .rp_ce(rp_ce), .rp_q(rp_q),
    .k_start(k_start), .k_ready(k_ready), .k_done(k_done),
    .k_begin(k_begin), .k_end(k_end), .k_sum(k_sum),
    .y_addr(y_addr), .y_ce(y_ce), .y_we(y_we), .y_d(y_d), .err_order(err_order)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  typedef struct { logic [15:0] a; logic [31:0] d; } ywr_t;
  typedef struct { logic [31:0] b; logic [31:0] e; } lrange_t;

  ywr_t        exp_y[$];
  lrange_t     exp_l[$];
  logic [31:0] rp_mem [0:15];
  logic [31:0] sum_tab[0:7];
  bit          exp_err;
  int          mli, lidx, ready_dly, done_dly;
  int          n_cmp, n_bad, cyc, done_cnt, rp_cnt, l_seen;
  bit          chk_en;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got unexpected event / expired bound, expected none", name);
  endtask

  // CSR semantics: row r spans [rowptr[r], rowptr[r+1]); non-empty rows take kernel sums in order.
  task automatic build_model(input int n);
    exp_err = 1'b0;
    for (int r = 0; r < n; r++) begin
      ywr_t w;
      w.a = 16'(r);
      if (rp_mem[r+1] > rp_mem[r]) begin
        exp_l.push_back('{b: rp_mem[r], e: rp_mem[r+1]});
        w.d = sum_tab[mli];
        mli++;
      end else begin
        w.d = 32'd0;
        if (rp_mem[r+1] < rp_mem[r]) exp_err = 1'b1;
      end
      exp_y.push_back(w);
    end
  endtask

  always @(posedge ap_clk) cyc <= cyc + 1;

  // Row-pointer RAM: one-cycle read latency.
  initial begin
    logic        rd;
    logic [16:0] a;
    rp_q = '0;
    forever begin
      @(negedge ap_clk);
      rd = rp_ce;
      a  = rp_addr;
      @(posedge ap_clk);
      #1;
      if (rd) rp_q = rp_mem[a[3:0]];
    end
  end

  // Kernel: k_ready after ready_dly waiting cycles, k_done done_dly cycles after k_ready.
  initial begin
    int ph, wc;
    ph = 0; wc = 0;
    k_ready = 1'b0; k_done = 1'b0; k_sum = '0;
    forever begin
      @(negedge ap_clk);
      k_ready = 1'b0;
      k_done  = 1'b0;
      if (!ap_rst_n) begin
        ph = 0; wc = 0;
      end else if (ph == 0 && k_start) begin
        if (wc < ready_dly) wc++;
        else begin
          k_ready = 1'b1;
          wc = 0;
          if (done_dly == 0) begin
            k_done = 1'b1; k_sum = sum_tab[lidx]; lidx++;
          end else ph = 1;
        end
      end else if (ph == 1) begin
        wc++;
        if (wc >= done_dly) begin
          k_done = 1'b1; k_sum = sum_tab[lidx]; lidx++; ph = 0; wc = 0;
        end
      end
    end
  end

  // Per-cycle compare against the model queues.
  initial begin
    bit      prev_k;
    lrange_t cur;
    prev_k = 1'b0;
    cur = '{b: '0, e: '0};
    forever begin
      @(negedge ap_clk);
      if (chk_en) begin
        check("ready_eq_done", ap_ready, ap_done);
        check("y_ce_eq_y_we", y_ce, y_we);
        if (ap_done) done_cnt++;
        if (rp_ce) rp_cnt++;
        if (y_we) begin
          if (exp_y.size() == 0) fail_now("y_extra_write");
          else begin
            ywr_t w;
            w = exp_y.pop_front();
            check("y_addr", y_addr, w.a);
            check("y_d", y_d, w.d);
          end
        end
        if (k_start) begin
          if (!prev_k) begin
            l_seen++;
            if (exp_l.size() == 0) fail_now("k_extra_launch");
            else cur = exp_l.pop_front();
          end
          check("k_begin", k_begin, cur.b);
          check("k_end", k_end, cur.e);
        end
      end
      prev_k = k_start;
    end
  end

  task automatic wait_done(output int t_done);
    int c;
    c = 0;
    while (!ap_done && c < 400) begin
      @(negedge ap_clk);
      c++;
    end
    if (!ap_done) fail_now("done_timeout");
    t_done = cyc;
  endtask

  // Runs `runs` back-to-back jobs of n rows (start held for runs>1); returns the
  // length in cycles from the accepting cycle through the final done cycle.
  task automatic start_run(input int n, input int runs, output int len);
    int t0, td;
    num_rows = 16'(n);
    for (int r = 0; r < runs; r++) build_model(n);
    done_cnt = 0; rp_cnt = 0; l_seen = 0;
    chk_en = 1'b1;
    @(negedge ap_clk);
    ap_start = 1'b1;
    t0 = cyc;
    if (runs == 1) begin
      @(negedge ap_clk);
      ap_start = 1'b0;
    end else begin
      wait_done(td);
      @(negedge ap_clk);
      check("b2b_idle_after_done", ap_idle, 1'b1);
      @(negedge ap_clk);
      ap_start = 1'b0;
    end
    wait_done(td);
    len = td - t0 + 1;
    repeat (3) @(negedge ap_clk);
    chk_en = 1'b0;
    check("y_all_written", 64'(exp_y.size()), 64'd0);
    check("launch_all_seen", 64'(exp_l.size()), 64'd0);
    check("done_pulses", 64'(done_cnt), 64'(runs));
    check("rp_reads", 64'(rp_cnt), (n == 0) ? 64'd0 : 64'(runs * (n + 1)));
    check("err_order", err_order, exp_err);
    check("idle_at_end", ap_idle, 1'b1);
  endtask

  task automatic new_test();
    exp_y.delete();
    exp_l.delete();
    mli = 0;
    lidx = 0;
  endtask

  initial begin
    int len, c;
    n_cmp = 0; n_bad = 0; cyc = 0; chk_en = 1'b0;
    done_cnt = 0; rp_cnt = 0; l_seen = 0;
    ready_dly = 0; done_dly = 1; mli = 0; lidx = 0;
    for (int i = 0; i < 16; i++) rp_mem[i] = '0;
    for (int i = 0; i < 8; i++) sum_tab[i] = '0;
    ap_rst_n = 1'b0; ap_start = 1'b0; num_rows = '0;

    repeat (3) @(negedge ap_clk);
    check("rst_idle", ap_idle, 1'b1);
    check("rst_done", ap_done, 1'b0);
    check("rst_rp_ce", rp_ce, 1'b0);
    check("rst_k_start", k_start, 1'b0);
    check("rst_y_we", y_we, 1'b0);
    check("rst_err", err_order, 1'b0);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);

    // 3 rows, middle row empty.
    new_test();
    rp_mem[0] = 0; rp_mem[1] = 2; rp_mem[2] = 2; rp_mem[3] = 5;
    sum_tab[0] = 7; sum_tab[1] = 9;
    ready_dly = 0; done_dly = 1;
    build_model(3);
    check("model_y0", exp_y[0].d, 32'd7);
    check("model_y1", exp_y[1].d, 32'd0);
    check("model_y2", exp_y[2].d, 32'd9);
    check("model_l1_end", exp_l[1].e, 32'd5);
    new_test();
    start_run(3, 1, len);
    check("t1_launches", 64'(l_seen), 64'd2);
    check("t1_len", 64'(len), 64'd17);

    // Zero rows: straight to DONE.
    new_test();
    start_run(0, 1, len);
    check("t2_len", 64'(len), 64'd2);

    // Decreasing row pointer: flagged, row written as 0, no launch.
    new_test();
    rp_mem[0] = 4; rp_mem[1] = 1;
    start_run(1, 1, len);
    check("t4_len", 64'(len), 64'd7);
    check("t4_launches", 64'(l_seen), 64'd0);
    repeat (3) @(negedge ap_clk);
    check("t4_err_sticky", err_order, 1'b1);

    // Slow k_ready with k_done coincident; clears the sticky error.
    new_test();
    rp_mem[0] = 0; rp_mem[1] = 3; rp_mem[2] = 4;
    sum_tab[0] = 11; sum_tab[1] = 32'hFFFF_FFFB;
    ready_dly = 4; done_dly = 0;
    start_run(2, 1, len);
    check("t3_launches", 64'(l_seen), 64'd2);

    // Asynchronous reset while row 1 of 3 is in the kernel.
    new_test();
    rp_mem[0] = 0; rp_mem[1] = 2; rp_mem[2] = 5; rp_mem[3] = 6;
    sum_tab[0] = 3; sum_tab[1] = 4; sum_tab[2] = 5;
    ready_dly = 0; done_dly = 8;
    num_rows = 16'd3;
    build_model(3);
    l_seen = 0;
    chk_en = 1'b1;
    @(negedge ap_clk);
    ap_start = 1'b1;
    @(negedge ap_clk);
    ap_start = 1'b0;
    c = 0;
    while (!(l_seen == 2 && !k_start) && c < 200) begin
      @(negedge ap_clk);
      c++;
    end
    if (c >= 200) fail_now("t5_reach_row1_run");
    chk_en = 1'b0;
    @(posedge ap_clk);
    #2;
    ap_rst_n = 1'b0;
    #1;
    check("t5_idle", ap_idle, 1'b1);
    check("t5_k_begin", k_begin, 32'd0);
    check("t5_k_end", k_end, 32'd0);
    check("t5_rp_addr", rp_addr, 17'd0);
    check("t5_outs", {ap_done, ap_ready, rp_ce, k_start, y_ce, y_we, err_order}, 7'd0);
    check("t5_y", {y_addr, y_d}, 48'd0);
    check("t5_y_pending", 64'(exp_y.size()), 64'd2);
    check("t5_l_pending", 64'(exp_l.size()), 64'd1);
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    new_test();
    done_dly = 1;
    start_run(3, 1, len);
    check("t5_rerun_launches", 64'(l_seen), 64'd3);

    // Back-to-back runs with start held high.
    new_test();
    rp_mem[0] = 1; rp_mem[1] = 3; rp_mem[2] = 3;
    sum_tab[0] = 21; sum_tab[1] = 22;
    ready_dly = 1; done_dly = 2;
    start_run(2, 2, len);
    check("t6_launches", 64'(l_seen), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
